// File: rtl/ppu_pkg.sv
// ---------------------------------------------------------------------------
// ppu_pkg
//   Shared types and widths for the PPU VRAM arbiter slice.
//   - owner_e   : which requester a VRAM read slot belongs to
//   - rd_tag_t  : {valid, owner} tag carried alongside a read through latency
//   - slot_e    : slot-select FSM state (owner of the slot now on the VRAM bus)
// ---------------------------------------------------------------------------
package ppu_pkg;

   localparam int VRAM_ADDR_W = 16;
   localparam int VRAM_DATA_W = 8;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_REN  = 2'd1,
      OWN_CPU  = 2'd2
   } owner_e;

   typedef struct packed {
      logic   valid;
      owner_e owner;
   } rd_tag_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REN  = 2'd1,
      ST_CPU  = 2'd2
   } slot_e;

   localparam rd_tag_t RD_TAG_EMPTY = '{valid: 1'b0, owner: OWN_NONE};

endpackage

// File: rtl/ppu_vram_arbiter_vram_rd_pipe.sv
// ---------------------------------------------------------------------------
// vram_rd_pipe
//   Carries the owner tag of each VRAM slot through the two-cycle VRAM read
//   latency and steers the returning data to the render or CPU port with a
//   registered 1-cycle valid pulse.
//   Ports:
//     clk, reset           system clock, synchronous active-high reset
//     tag_in               tag of the slot selected this cycle
//     vram_rdata           VRAM read data (valid 1 cycle after vram_addr)
//     ren_rvalid/ren_rdata render read return
//     cpu_rvalid/cpu_rdata CPU read return
// ---------------------------------------------------------------------------
import ppu_pkg::*;

module vram_rd_pipe #(
   parameter int DATA_W = VRAM_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  rd_tag_t           tag_in,
   input  logic [DATA_W-1:0] vram_rdata,
   output logic              ren_rvalid,
   output logic [DATA_W-1:0] ren_rdata,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata
);

   // s0 lines up with vram_addr, s1 with vram_rdata.
   rd_tag_t s0_q;
   rd_tag_t s1_q;

   logic ren_hit;
   logic cpu_hit;

   assign ren_hit = s1_q.valid && (s1_q.owner == OWN_REN);
   assign cpu_hit = s1_q.valid && (s1_q.owner == OWN_CPU);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values and the shift order cannot race.
   always_ff @(posedge clk) begin
      if (reset) begin
         s0_q       <= RD_TAG_EMPTY;
         s1_q       <= RD_TAG_EMPTY;
         ren_rvalid <= 1'b0;
         ren_rdata  <= '0;
         cpu_rvalid <= 1'b0;
         cpu_rdata  <= '0;
      end else begin
         s0_q       <= tag_in;
         s1_q       <= s0_q;
         ren_rvalid <= ren_hit;
         cpu_rvalid <= cpu_hit;
         if (ren_hit) ren_rdata <= vram_rdata;
         if (cpu_hit) cpu_rdata <= vram_rdata;
      end
   end

endmodule

// File: rtl/ppu_vram_arbiter.sv
// ---------------------------------------------------------------------------
// ppu_vram_arbiter
//   Shares the single-port PPU VRAM between the render fetcher (fixed
//   priority, level request) and the CPU PPUDATA path (one-entry latched
//   request with busy flag). One VRAM access per clk; read data is returned
//   to its owner three cycles after the slot is granted.
//   Build option: define PPU_VRAM_STARVE_GUARD_EN to force a CPU slot after
//   STARVE_LIMIT consecutive render wins while a CPU request is pending.
//   Ports:
//     clk, reset                       clock, synchronous active-high reset
//     ren_req/ren_addr/ren_gnt         render fetch request / grant (comb)
//     ren_rvalid/ren_rdata             render read return
//     cpu_req/cpu_we/cpu_addr/cpu_wdata CPU access pulse and operands
//     cpu_busy                         CPU entry pending or read in flight
//     cpu_rvalid/cpu_rdata             CPU read return
//     cpu_overrun                      sticky: cpu_req seen while busy
//     vram_addr/vram_we/vram_wdata     registered VRAM command
//     vram_rdata                       VRAM read data
// ---------------------------------------------------------------------------
import ppu_pkg::*;

module ppu_vram_arbiter #(
   parameter int ADDR_W = VRAM_ADDR_W,
   parameter int DATA_W = VRAM_DATA_W
`ifdef PPU_VRAM_STARVE_GUARD_EN
   , parameter int STARVE_LIMIT = 8
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ren_req,
   input  logic [ADDR_W-1:0] ren_addr,
   output logic              ren_gnt,
   output logic              ren_rvalid,
   output logic [DATA_W-1:0] ren_rdata,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_busy,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_overrun,
   output logic [ADDR_W-1:0] vram_addr,
   output logic              vram_we,
   output logic [DATA_W-1:0] vram_wdata,
   input  logic [DATA_W-1:0] vram_rdata
);

   slot_e             state_q;
   slot_e             state_d;

   logic              ent_valid_q;
   logic              ent_we_q;
   logic [ADDR_W-1:0] ent_addr_q;
   logic [DATA_W-1:0] ent_wdata_q;

   logic              busy_q;
   logic              overrun_q;
   logic [ADDR_W-1:0] vram_addr_q;
   logic              vram_we_q;
   logic [DATA_W-1:0] vram_wdata_q;

   logic              cpu_issue;
   logic              cpu_accept;
   logic              cpu_done;
   logic              starve_hit;
   rd_tag_t           tag_d;

   // ---------------- starve guard ----------------
`ifdef PPU_VRAM_STARVE_GUARD_EN
   localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

   logic [STARVE_W-1:0] starve_cnt_q;

   assign starve_hit = ent_valid_q && (starve_cnt_q == STARVE_W'(STARVE_LIMIT));

   // Counts render wins only while the CPU entry waits; any CPU issue clears it.
   always_ff @(posedge clk) begin
      if (reset) begin
         starve_cnt_q <= '0;
      end else if (cpu_issue) begin
         starve_cnt_q <= '0;
      end else if ((state_d == ST_REN) && ent_valid_q) begin
         starve_cnt_q <= starve_cnt_q + 1'b1;
      end
   end
`else
   assign starve_hit = 1'b0;
`endif

   // ---------------- slot select ----------------
   // NOTE: every always_comb output gets a default first so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      state_d = ST_IDLE;
      ren_gnt = 1'b0;
      if (ren_req && !starve_hit) begin
         state_d = ST_REN;
         ren_gnt = !reset;
      end else if (ent_valid_q) begin
         state_d = ST_CPU;
      end
   end

   assign cpu_issue = (state_d == ST_CPU);

   // Only reads need a return; a CPU write slot carries an invalid tag.
   always_comb begin
      tag_d = RD_TAG_EMPTY;
      case (state_d)
         ST_REN:  tag_d = '{valid: 1'b1,       owner: OWN_REN};
         ST_CPU:  tag_d = '{valid: !ent_we_q,  owner: OWN_CPU};
         default: tag_d = RD_TAG_EMPTY;
      endcase
   end

   // A new CPU access is taken only when nothing CPU-side is outstanding.
   assign cpu_accept = cpu_req && !busy_q;
   // Busy ends after the write cycle on the bus, or on the read-return pulse.
   assign cpu_done   = ((state_q == ST_CPU) && vram_we_q) || cpu_rvalid;

   // ---------------- state, CPU entry, VRAM command ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         ent_valid_q  <= 1'b0;
         ent_we_q     <= 1'b0;
         ent_addr_q   <= '0;
         ent_wdata_q  <= '0;
         busy_q       <= 1'b0;
         overrun_q    <= 1'b0;
         vram_addr_q  <= '0;
         vram_we_q    <= 1'b0;
         vram_wdata_q <= '0;
      end else begin
         state_q <= state_d;

         case (state_d)
            ST_REN: begin
               vram_addr_q <= ren_addr;
               vram_we_q   <= 1'b0;
            end
            ST_CPU: begin
               vram_addr_q  <= ent_addr_q;
               vram_we_q    <= ent_we_q;
               vram_wdata_q <= ent_wdata_q;
            end
            default: vram_we_q <= 1'b0;  // idle slot: address holds
         endcase

         if (cpu_issue) ent_valid_q <= 1'b0;

         if (cpu_accept) begin
            ent_valid_q <= 1'b1;
            ent_we_q    <= cpu_we;
            ent_addr_q  <= cpu_addr;
            ent_wdata_q <= cpu_wdata;
         end else if (cpu_req) begin
            overrun_q <= 1'b1;
         end

         if (cpu_accept)    busy_q <= 1'b1;
         else if (cpu_done) busy_q <= 1'b0;
      end
   end

   assign cpu_busy    = busy_q;
   assign cpu_overrun = overrun_q;
   assign vram_addr   = vram_addr_q;
   assign vram_we     = vram_we_q;
   assign vram_wdata  = vram_wdata_q;

   // ---------------- read return ----------------
   vram_rd_pipe #(
      .DATA_W(DATA_W)
   ) u_rd_pipe (
      .clk        (clk),
      .reset      (reset),
      .tag_in     (tag_d),
      .vram_rdata (vram_rdata),
      .ren_rvalid (ren_rvalid),
      .ren_rdata  (ren_rdata),
      .cpu_rvalid (cpu_rvalid),
      .cpu_rdata  (cpu_rdata)
   );

endmodule

// File: tb/tb_ppu_vram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ppu_vram_arbiter
//   Directed bench for ppu_vram_arbiter. The VRAM model returns
//   addr[7:0] + addr[15:8] one cycle after the address, so expected read
//   data is easy to hand-compute (0x2000 -> 0x20, 0x3F00 -> 0x3F, ...).
// ---------------------------------------------------------------------------
module tb_ppu_vram_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        ren_req;
   logic [15:0] ren_addr;
   logic        ren_gnt;
   logic        ren_rvalid;
   logic [7:0]  ren_rdata;
   logic        cpu_req;
   logic        cpu_we;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_busy;
   logic        cpu_rvalid;
   logic [7:0]  cpu_rdata;
   logic        cpu_overrun;
   logic [15:0] vram_addr;
   logic        vram_we;
   logic [7:0]  vram_wdata;
   logic [7:0]  vram_rdata = 8'h00;

   int n_checks = 0;
   int n_errors = 0;

`ifdef PPU_VRAM_STARVE_GUARD_EN
   localparam int REN_LEN  = 14;
   localparam int CPU_SLOT = 9;
`else
   localparam int REN_LEN  = 12;
   localparam int CPU_SLOT = 12;
`endif

   ppu_vram_arbiter dut (
      .clk         (clk),
      .reset       (reset),
      .ren_req     (ren_req),
      .ren_addr    (ren_addr),
      .ren_gnt     (ren_gnt),
      .ren_rvalid  (ren_rvalid),
      .ren_rdata   (ren_rdata),
      .cpu_req     (cpu_req),
      .cpu_we      (cpu_we),
      .cpu_addr    (cpu_addr),
      .cpu_wdata   (cpu_wdata),
      .cpu_busy    (cpu_busy),
      .cpu_rvalid  (cpu_rvalid),
      .cpu_rdata   (cpu_rdata),
      .cpu_overrun (cpu_overrun),
      .vram_addr   (vram_addr),
      .vram_we     (vram_we),
      .vram_wdata  (vram_wdata),
      .vram_rdata  (vram_rdata)
   );

   always #5 clk = ~clk;

   // Read-only VRAM model with one cycle of latency.
   always @(posedge clk) vram_rdata <= vram_addr[7:0] + vram_addr[15:8];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset     = 1'b1;
      ren_req   = 1'b0;
      ren_addr  = 16'h0000;
      cpu_req   = 1'b0;
      cpu_we    = 1'b0;
      cpu_addr  = 16'h0000;
      cpu_wdata = 8'h00;

      // ---------------- reset state ----------------
      tick();
      tick();
      check("rst_ren_rvalid", 32'(ren_rvalid), 32'd0);
      check("rst_cpu_busy",   32'(cpu_busy),   32'd0);
      check("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
      check("rst_overrun",    32'(cpu_overrun), 32'd0);
      check("rst_vram_addr",  32'(vram_addr),  32'd0);
      check("rst_vram_we",    32'(vram_we),    32'd0);
      check("rst_vram_wdata", 32'(vram_wdata), 32'd0);
      reset = 1'b0;

      // ---------------- render burst 0x2000..0x2003 ----------------
      for (int k = 0; k < 8; k++) begin
         ren_req  = (k < 4);
         ren_addr = (k < 4) ? 16'h2000 + 16'(k) : 16'h0000;
         #1;
         check("burst_gnt", 32'(ren_gnt), 32'(k < 4));
         if (k >= 1 && k <= 4) check("burst_vaddr", 32'(vram_addr), 32'(16'h2000 + 16'(k - 1)));
         check("burst_rvalid", 32'(ren_rvalid), 32'(k >= 3 && k <= 6));
         if (k >= 3 && k <= 6) check("burst_rdata", 32'(ren_rdata), 32'(8'h20 + 8'(k - 3)));
         check("burst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
         tick();
      end

      // ---------------- CPU write, render idle ----------------
      for (int k = 0; k < 6; k++) begin
         cpu_req   = (k == 0);
         cpu_we    = 1'b1;
         cpu_addr  = 16'h23C0;
         cpu_wdata = 8'h5A;
         #1;
         check("wr_busy",   32'(cpu_busy), 32'(k >= 1 && k <= 2));
         check("wr_vram_we", 32'(vram_we), 32'(k == 2));
         if (k == 2) begin
            check("wr_vaddr",  32'(vram_addr),  32'h23C0);
            check("wr_vwdata", 32'(vram_wdata), 32'h5A);
         end
         check("wr_rvalid", 32'(cpu_rvalid) | 32'(ren_rvalid), 32'd0);
         tick();
      end
      cpu_req = 1'b0;
      cpu_we  = 1'b0;

      // ---------------- CPU read 0x3F00 under continuous render ----------------
      for (int k = 0; k < 20; k++) begin
         cpu_req  = (k == 0);
         cpu_we   = 1'b0;
         cpu_addr = 16'h3F00;
         ren_req  = (k < REN_LEN);
         ren_addr = 16'h2100;
         #1;
         check("starve_gnt", 32'(ren_gnt), 32'((k < REN_LEN) && (k != CPU_SLOT)));
         if (k >= 1 && k <= CPU_SLOT)
            check("starve_no_cpu_issue", 32'(vram_addr == 16'h3F00), 32'd0);
         if (k == CPU_SLOT + 1) check("starve_cpu_vaddr", 32'(vram_addr), 32'h3F00);
         check("starve_busy", 32'(cpu_busy), 32'(k >= 1 && k <= CPU_SLOT + 3));
         check("starve_cpu_rvalid", 32'(cpu_rvalid), 32'(k == CPU_SLOT + 3));
         if (k == CPU_SLOT + 3) check("starve_cpu_rdata", 32'(cpu_rdata), 32'h3F);
         check("starve_ren_rvalid", 32'(ren_rvalid),
               32'((k >= 3) && (k - 3 < REN_LEN) && (k - 3 != CPU_SLOT)));
         if (ren_rvalid) check("starve_ren_rdata", 32'(ren_rdata), 32'h21);
         check("starve_overrun", 32'(cpu_overrun), 32'd0);
         tick();
      end
      ren_req = 1'b0;

      // ---------------- overrun: second cpu_req while busy ----------------
      for (int k = 0; k < 8; k++) begin
         cpu_req   = (k <= 1);
         cpu_we    = (k == 1);
         cpu_addr  = (k == 1) ? 16'h1111 : 16'h0005;
         cpu_wdata = 8'hEE;
         #1;
         check("ovr_flag", 32'(cpu_overrun), 32'(k >= 2));
         check("ovr_busy", 32'(cpu_busy), 32'(k >= 1 && k <= 4));
         check("ovr_no_write", 32'(vram_we), 32'd0);
         if (k == 2) check("ovr_vaddr", 32'(vram_addr), 32'h0005);
         check("ovr_cpu_rvalid", 32'(cpu_rvalid), 32'(k == 4));
         if (k == 4) check("ovr_cpu_rdata", 32'(cpu_rdata), 32'h05);
         tick();
      end
      cpu_req = 1'b0;
      cpu_we  = 1'b0;

      // ---------------- reset with two render reads in flight ----------------
      for (int k = 0; k < 8; k++) begin
         ren_req  = (k < 2);
         ren_addr = 16'h2000 + 16'(k);
         reset    = (k == 2);
         #1;
         if (k == 2) check("midrst_overrun_before", 32'(cpu_overrun), 32'd1);
         if (k == 3) begin
            check("midrst_gnt",       32'(ren_gnt),     32'd0);
            check("midrst_busy",      32'(cpu_busy),    32'd0);
            check("midrst_overrun",   32'(cpu_overrun), 32'd0);
            check("midrst_vaddr",     32'(vram_addr),   32'd0);
            check("midrst_vwe",       32'(vram_we),     32'd0);
            check("midrst_vwdata",    32'(vram_wdata),  32'd0);
            check("midrst_ren_rdata", 32'(ren_rdata),   32'd0);
            check("midrst_cpu_rdata", 32'(cpu_rdata),   32'd0);
         end
         if (k >= 2) begin
            check("midrst_ren_rvalid", 32'(ren_rvalid), 32'd0);
            check("midrst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
         end
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
